// File: rtl/alu_pkg.sv
// Shared datapath constants and state encodings for the ALU blocks.
package alu_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SLICE_W = 4;
  localparam int unsigned N_SLICE = DATA_W / SLICE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/ripple_borrow_4_bit.sv
// Combinational 4-bit ripple-borrow subtractor built from 1-bit full-subtractor cells.
module ripple_borrow_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);

  logic [4:0] brw;

  assign brw[0] = bin;

  // Full subtractor: borrow when a < b, or a == b with an incoming borrow.
  for (genvar i = 0; i < 4; i++) begin : g_fs
    logic axb;
    assign axb        = a[i] ^ b[i];
    assign diff[i]    = axb ^ brw[i];
    assign brw[i + 1] = (~a[i] & b[i]) | (~axb & brw[i]);
  end

  assign bout = brw[4];

endmodule

// File: rtl/sub_serial_16.sv
// Multi-cycle subtractor: inp1 - inp2 - bin, one 4-bit slice per clock, LSB slice first.
module sub_serial_16
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             underflow
);

  localparam int unsigned NS       = WIDTH / SLICE;
  localparam int unsigned IDX_W    = $clog2(NS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NS - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             uf_q, uf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SLICE-1:0] sl_a, sl_b, sl_diff;
  logic             sl_bout;

  // Operand slice mux feeding the single shared slice.
  assign sl_a = a_q[idx_q*SLICE +: SLICE];
  assign sl_b = b_q[idx_q*SLICE +: SLICE];

  ripple_borrow_4_bit u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .bin  (borrow_q),
    .diff (sl_diff),
    .bout (sl_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    uf_d     = uf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = inp1;
          b_d      = inp2;
          borrow_d = bin;
          idx_d    = '0;
          diff_d   = '0;
          bout_d   = 1'b0;
          uf_d     = 1'b0;
        end
      end
      RUN: begin
        diff_d[idx_q*SLICE +: SLICE] = sl_diff;
        borrow_d = sl_bout;
        idx_d    = IDX_W'(idx_q + 1'b1);
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          bout_d  = sl_bout;
          uf_d    = sl_bout;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      uf_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      uf_q     <= uf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_sub_serial_16.sv
// Directed bench for sub_serial_16: vector table plus busy-start and mid-run reset sequences.
module tb_sub_serial_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] inp1, inp2;
  logic        bin;
  logic        busy, done, bout, underflow;
  logic [15:0] diff;

  int n_checks = 0;
  int n_fail   = 0;

  sub_serial_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .inp1      (inp1),
    .inp2      (inp2),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .bout      (bout),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic [15:0] exp_diff;
    logic        exp_bout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, check accept-edge effects, latency, result and pulse width.
  task automatic run_op(input vec_t v);
    int cyc;
    bit seen;
    start = 1'b1; inp1 = v.a; inp2 = v.b; bin = v.bi;
    step();
    start = 1'b0; inp1 = 16'hDEAD; inp2 = 16'hBEEF; bin = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("diff_cleared", 32'(diff), 32'd0);
    chk("uf_cleared", 32'(underflow), 32'd0);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      step();
      if (done) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done within 10 cycles, expected done");
      return;
    end
    chk("done_edge_after_accept", 32'(cyc), 32'd4);
    chk("diff", 32'(diff), 32'(v.exp_diff));
    chk("bout", 32'(bout), 32'(v.exp_bout));
    chk("underflow", 32'(underflow), 32'(v.exp_bout));
    chk("busy_in_done", 32'(busy), 32'd1);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_low_idle", 32'(busy), 32'd0);
    chk("diff_hold", 32'(diff), 32'(v.exp_diff));
    chk("uf_hold", 32'(underflow), 32'(v.exp_bout));
  endtask

  vec_t vecs[10];
  int   n_done;

  initial begin
    vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0};
    vecs[1] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
    vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0};
    vecs[4] = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[6] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0};
    vecs[7] = '{16'h1234, 16'hABCD, 1'b0, 16'h6667, 1'b1};
    vecs[8] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[9] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0};

    rst_n = 1'b0; start = 1'b0; inp1 = '0; inp2 = '0; bin = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);

    // Reset and start together: reset wins.
    start = 1'b1; inp1 = 16'h0000; inp2 = 16'h0001;
    step();
    chk("rst_start_busy", 32'(busy), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rst_start_still_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i]);
      // Underflow stays sticky across idle cycles.
      if (i == 2) begin
        step(); step(); step();
        chk("uf_sticky_idle", 32'(underflow), 32'd1);
        chk("bout_sticky_idle", 32'(bout), 32'd1);
      end
    end

    // Start pulsed while busy: ignored, single done, first result kept.
    start = 1'b1; inp1 = 16'h5555; inp2 = 16'h1111; bin = 1'b0;
    step();
    start = 1'b0;
    step();
    start = 1'b1; inp1 = 16'h0000; inp2 = 16'hFFFF; bin = 1'b1;
    step();
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) begin
        n_done++;
        chk("busy_start_diff", 32'(diff), 32'h4444);
        chk("busy_start_bout", 32'(bout), 32'd0);
      end
      step();
    end
    for (int i = 0; i < 6; i++) begin
      if (done) n_done++;
      step();
    end
    chk("busy_start_done_count", 32'(n_done), 32'd1);
    chk("busy_start_diff_hold", 32'(diff), 32'h4444);

    // Reset asserted at edge k+2 of a running operation.
    start = 1'b1; inp1 = 16'h0000; inp2 = 16'h0001; bin = 1'b0;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) n_done++;
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    chk("abort_uf", 32'(underflow), 32'd0);
    run_op('{16'hC0DE, 16'h0FFF, 1'b1, 16'hB0DE, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, expected finish");
    $fatal(1);
  end

endmodule
